wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Consumer end of the MEM/WB pipeline register: it reads the latched WB control bits, memory read data, ALU result and destination register.
- Selects the writeback value and commits it into a 32-entry general-purpose register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Keeps a retired-writeback counter for debug and performance visibility.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)
- CNT_W, 32, width of the retired-writeback counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mem_control_wb  input  2  latched WB control; bit1 = RegWrite, bit0 = MemtoReg
- mem_read_data  input  DATA_W  latched data-memory read value
- mem_ALU_result  input  DATA_W  latched ALU result / address
- mem_Write_reg  input  ADDR_W  latched destination register index
- rs_addr  input  ADDR_W  ID-stage read port A index
- rt_addr  input  ADDR_W  ID-stage read port B index
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_write_data  output  DATA_W  selected writeback value, also the EX forwarding source
- wb_write_reg  output  ADDR_W  writeback destination, equal to mem_Write_reg
- wb_regwrite  output  1  effective write enable: RegWrite and (mem_Write_reg != 0)
- retire_count  output  CNT_W  count of committed register writes

Behaviour:
- wb_write_data is combinational: mem_read_data when MemtoReg = 1, else mem_ALU_result.
- wb_regwrite and wb_write_reg are combinational from the inputs. Zero added latency: the value is visible the same cycle the latch presents it.
- Commit: on the rising clk edge with reset = 0 and wb_regwrite = 1, regs[mem_Write_reg] <= wb_write_data.
- Register 0 is never written; writes addressed to it are dropped and not counted.
- Read ports are combinational:
  - index 0 returns 0.
  - Otherwise, if wb_regwrite = 1 and the index equals wb_write_reg, the port returns wb_write_data (bypass, write-before-read semantics).
  - Otherwise it returns regs[index].
- rs and rt bypass independently; both may hit the same write.
- retire_count increments by 1 on each edge where a commit occurs. It wraps from 2**CNT_W-1 to 0 with no flag.
- Reset, synchronous, has priority over everything:
  - All registers clear to 0 and retire_count clears to 0.
  - A write presented in the reset cycle is discarded and not counted.
  - Reset asserted mid-stream simply drops that cycle's writeback.
- Reset values of the outputs:
  - After reset, rs_data and rt_data read 0 unless bypass is active.
  - wb_* outputs follow the inputs; the upstream latch also resets to 0, so wb_* are 0 during reset.
- RegWrite = 0 with MemtoReg = 1: no commit. wb_write_data still shows mem_read_data, and the bypass does not fire.
- X on mem_read_data while MemtoReg = 0 must not propagate into wb_write_data.

Decomposition:
- Shared package holds:
  - WB_REGWRITE = 1 and WB_MEMTOREG = 0 (control bit indices)
  - REG_ZERO = 0
  - DATA_W, ADDR_W
  The MEM and ID stages import the same package.
- One sub-module: reg_file, containing the 32xDATA_W storage, the reset clear, the write port, and the two bypassing read ports.
- The writeback mux and retire counter stay in wb_stage.

Test Plan:
- Reset then read: read all rs_addr 0..31 -> rs_data = 0; retire_count = 0.
- ALU writeback: control = 2'b10, ALU = 0x0000_1234, reg = 5; next cycle rs_addr = 5 -> 0x0000_1234; retire_count = 1.
- Load writeback: control = 2'b11, read_data = 0xDEAD_BEEF, reg = 9, with rt_addr = 9 in the same cycle -> rt_data = 0xDEAD_BEEF via bypass; after the edge, non-bypassed read also = 0xDEAD_BEEF.
- Writes that must not commit:
  - control = 2'b10, reg = 0, ALU = 0xFFFF_FFFF -> rs_addr = 0 reads 0, wb_regwrite = 0, retire_count unchanged.
  - control = 2'b01, reg = 7 -> reg 7 unchanged, no bypass.
- Reset mid-operation: reg 3 = 0x55; assert reset in the same cycle as write 0xAA to reg 3 -> reg 3 = 0 and retire_count = 0 after release.
- Counter wrap: retire_count preloaded to 0xFFFF_FFFF (or CNT_W = 4 build, 16 writes) -> next commit gives 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared writeback definitions: WB control bit positions, datapath widths and the hardwired zero register.
// The MEM and ID stages import this package as well.
package wb_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_reg_file.sv
// 32-entry general-purpose register file: synchronous clear, one write port and two read ports.
// Both read ports forward the write that is in flight in the same cycle.
module wb_stage_reg_file #(
    parameter int DATA_W   = wb_stage_pkg::DATA_W,
    parameter int ADDR_W   = wb_stage_pkg::ADDR_W,
    parameter int NUM_REGS = wb_stage_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);
    import wb_stage_pkg::*;

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;

    // Storage: reset wins over the write port; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port A with write-before-read forwarding.
    always_comb begin
        rs_data_s = {DATA_W{1'b0}};
        if (rs_addr == REG_ZERO) begin
            rs_data_s = {DATA_W{1'b0}};
        end else if (we && (rs_addr == waddr)) begin
            rs_data_s = wdata;
        end else begin
            rs_data_s = regs_r[rs_addr];
        end
    end

    // Read port B with write-before-read forwarding.
    always_comb begin
        rt_data_s = {DATA_W{1'b0}};
        if (rt_addr == REG_ZERO) begin
            rt_data_s = {DATA_W{1'b0}};
        end else if (we && (rt_addr == waddr)) begin
            rt_data_s = wdata;
        end else begin
            rt_data_s = regs_r[rt_addr];
        end
    end

    assign rs_data = rs_data_s;
    assign rt_data = rt_data_s;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the value to write back from the MEM/WB latch, commits it to the
// register file and counts retired register writes.
module wb_stage #(
    parameter int DATA_W   = wb_stage_pkg::DATA_W,
    parameter int ADDR_W   = wb_stage_pkg::ADDR_W,
    parameter int NUM_REGS = wb_stage_pkg::NUM_REGS,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_control_wb,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] mem_ALU_result,
    input  logic [ADDR_W-1:0] mem_Write_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_write_data,
    output logic [ADDR_W-1:0] wb_write_reg,
    output logic              wb_regwrite,
    output logic [CNT_W-1:0]  retire_count
);
    import wb_stage_pkg::*;

    logic [DATA_W-1:0] wb_data_s;
    logic              wb_we_s;
    logic [CNT_W-1:0]  retire_count_r;

    // Writeback mux; an if/else keeps an unknown load value out while the ALU path is selected.
    always_comb begin
        wb_data_s = {DATA_W{1'b0}};
        if (mem_control_wb[WB_MEMTOREG]) begin
            wb_data_s = mem_read_data;
        end else begin
            wb_data_s = mem_ALU_result;
        end
    end

    assign wb_we_s = mem_control_wb[WB_REGWRITE] && (mem_Write_reg != REG_ZERO);

    // Retired-writeback counter, wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count_r <= {CNT_W{1'b0}};
        end else if (wb_we_s) begin
            retire_count_r <= retire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    wb_stage_reg_file #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we_s),
        .waddr   (mem_Write_reg),
        .wdata   (wb_data_s),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    assign wb_write_data = wb_data_s;
    assign wb_write_reg  = mem_Write_reg;
    assign wb_regwrite   = wb_we_s;
    assign retire_count  = retire_count_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage, built with a 4-bit retire counter so that a wrap is reachable.
module tb_wb_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    localparam logic [2:0] K_RS  = 3'd0;
    localparam logic [2:0] K_RT  = 3'd1;
    localparam logic [2:0] K_WBD = 3'd2;
    localparam logic [2:0] K_WBE = 3'd3;
    localparam logic [2:0] K_WBR = 3'd4;
    localparam logic [2:0] K_CNT = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] id;
        logic [31:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        ctl;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] wreg;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_write_data;
    logic [ADDR_W-1:0] wb_write_reg;
    logic              wb_regwrite;
    logic [CNT_W-1:0]  retire_count;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    string       mon_name;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        done_r = 1'b0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_control_wb (ctl),
        .mem_read_data  (rd_data),
        .mem_ALU_result (alu),
        .mem_Write_reg  (wreg),
        .rs_addr        (rs),
        .rt_addr        (rt),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .wb_write_data  (wb_write_data),
        .wb_write_reg   (wb_write_reg),
        .wb_regwrite    (wb_regwrite),
        .retire_count   (retire_count)
    );

    // Monitor: every falling edge, compare the outputs against everything queued for this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_RS:    begin mon_act = rs_data;                   mon_name = "rs_data"; end
                K_RT:    begin mon_act = rt_data;                   mon_name = "rt_data"; end
                K_WBD:   begin mon_act = wb_write_data;             mon_name = "wb_write_data"; end
                K_WBE:   begin mon_act = {31'd0, wb_regwrite};      mon_name = "wb_regwrite"; end
                K_WBR:   begin mon_act = {27'd0, wb_write_reg};     mon_name = "wb_write_reg"; end
                K_CNT:   begin mon_act = {28'd0, retire_count};     mon_name = "retire_count"; end
                default: begin mon_act = 32'hxxxx_xxxx;             mon_name = "unknown"; end
            endcase
            n_cmp++;
            if (mon_act !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s #%0d: got %h expected %h", mon_name, mon_e.id, mon_act, mon_e.exp);
            end
        end
    end

    // Watchdog: flag a failure if the stimulus does not complete in time.
    initial begin
        repeat (5000) @(posedge clk);
        if (!done_r) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not complete within 5000 cycles");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s (direct): got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic expect_val(input logic [2:0] k, input int id, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.id   = id[15:0];
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [1:0] c, input logic [31:0] d,
                         input logic [31:0] a, input logic [4:0] w,
                         input logic [4:0] s, input logic [4:0] t);
        @(posedge clk);
        #1;
        reset   = r;
        ctl     = c;
        rd_data = d;
        alu     = a;
        wreg    = w;
        rs      = s;
        rt      = t;
    endtask

    // Stimulus and expectations.
    initial begin
        reset = 1'b1; ctl = 2'b00; rd_data = 32'd0; alu = 32'd0;
        wreg = 5'd0; rs = 5'd0; rt = 5'd0;

        // Reset: wb outputs zero while the latch is zero, counter cleared.
        drive(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        expect_val(K_WBD, 1, 32'd0);
        expect_val(K_WBE, 2, 32'd0);
        expect_val(K_WBR, 3, 32'd0);
        drive(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        expect_val(K_CNT, 4, 32'd0);
        #1;
        check_now("retire_count", {28'd0, retire_count}, 32'd0);
        check_now("wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check_now("wb_write_reg", {27'd0, wb_write_reg}, 32'd0);
        check_now("wb_write_data", wb_write_data, 32'd0);

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, i[4:0], 5'd31 - i[4:0]);
            expect_val(K_RS, 100 + i, 32'd0);
            expect_val(K_RT, 200 + i, 32'd0);
        end
        expect_val(K_CNT, 5, 32'd0);

        // ALU writeback to r5, bypass visible in the same cycle.
        drive(1'b0, 2'b10, 32'h5555_0000, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
        expect_val(K_WBD, 10, 32'h0000_1234);
        expect_val(K_WBE, 11, 32'd1);
        expect_val(K_WBR, 12, 32'd5);
        expect_val(K_RS,  13, 32'h0000_1234);
        expect_val(K_CNT, 14, 32'd0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
        expect_val(K_RS,  15, 32'h0000_1234);
        expect_val(K_CNT, 16, 32'd1);

        // Load writeback to r9 with rt bypass; rs on r5 reads storage.
        drive(1'b0, 2'b11, 32'hDEAD_BEEF, 32'h0BAD_0000, 5'd9, 5'd5, 5'd9);
        expect_val(K_WBD, 20, 32'hDEAD_BEEF);
        expect_val(K_RT,  21, 32'hDEAD_BEEF);
        expect_val(K_RS,  22, 32'h0000_1234);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9);
        expect_val(K_RS,  23, 32'hDEAD_BEEF);
        expect_val(K_RT,  24, 32'hDEAD_BEEF);
        expect_val(K_CNT, 25, 32'd2);

        // Write to r0 is dropped.
        drive(1'b0, 2'b10, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        expect_val(K_WBE, 30, 32'd0);
        expect_val(K_WBD, 31, 32'hFFFF_FFFF);
        expect_val(K_RS,  32, 32'd0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        expect_val(K_RS,  33, 32'd0);
        expect_val(K_CNT, 34, 32'd2);

        // MemtoReg without RegWrite: data shown, no commit, no bypass.
        drive(1'b0, 2'b01, 32'h7777_7777, 32'h1111_1111, 5'd7, 5'd7, 5'd7);
        expect_val(K_WBE, 40, 32'd0);
        expect_val(K_WBD, 41, 32'h7777_7777);
        expect_val(K_RS,  42, 32'd0);
        expect_val(K_RT,  43, 32'd0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd7, 5'd0);
        expect_val(K_RS,  44, 32'd0);
        expect_val(K_CNT, 45, 32'd2);

        // Both ports hit the same in-flight write.
        drive(1'b0, 2'b10, 32'd0, 32'hCAFE_F00D, 5'd12, 5'd12, 5'd12);
        expect_val(K_RS,  50, 32'hCAFE_F00D);
        expect_val(K_RT,  51, 32'hCAFE_F00D);

        // Unknown load data must not leak onto the ALU path.
        drive(1'b0, 2'b10, 32'hxxxx_xxxx, 32'h0000_00AA, 5'd13, 5'd12, 5'd13);
        expect_val(K_WBD, 52, 32'h0000_00AA);
        expect_val(K_RS,  53, 32'hCAFE_F00D);
        expect_val(K_RT,  54, 32'h0000_00AA);
        expect_val(K_CNT, 55, 32'd3);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd13, 5'd12);
        expect_val(K_RS,  56, 32'h0000_00AA);
        expect_val(K_CNT, 57, 32'd4);

        // Reset in the same cycle as a write to r3: everything cleared.
        drive(1'b0, 2'b10, 32'd0, 32'h0000_0055, 5'd3, 5'd0, 5'd0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
        expect_val(K_RS,  60, 32'h0000_0055);
        expect_val(K_CNT, 61, 32'd5);
        drive(1'b1, 2'b10, 32'd0, 32'h0000_00AA, 5'd3, 5'd3, 5'd5);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd5);
        expect_val(K_RS,  62, 32'd0);
        expect_val(K_RT,  63, 32'd0);
        expect_val(K_CNT, 64, 32'd0);

        // Sixteen commits wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 2'b10, 32'd0, 32'h0000_0100 + i, 5'd1 + i[4:0], 5'd0, 5'd0);
            if (i == 15) begin
                expect_val(K_CNT, 70, 32'd15);
            end
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd1, 5'd16);
        expect_val(K_CNT, 71, 32'd0);
        expect_val(K_RS,  72, 32'h0000_0100);
        expect_val(K_RT,  73, 32'h0000_010F);
        drive(1'b0, 2'b10, 32'd0, 32'h0000_0200, 5'd2, 5'd0, 5'd0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd2, 5'd0);
        expect_val(K_CNT, 74, 32'd1);
        expect_val(K_RS,  75, 32'h0000_0200);

        @(negedge clk);
        #1;
        done_r = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
